store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of store entries (power of two, >=2).
REQ-002 SHALL have port cpu_clock_i  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port cpu_reset_i  in  1  reset; synchronous and active-high.
REQ-004 SHALL have port flush_i  in  1  pipeline flush; discards speculative (uncommitted) stores.
REQ-005 SHALL have ports enqueue_en_i 1, enqueue_address_i 30, enqueue_data_i 32, enqueue_bm_i 4, enqueue_io_i 1, enqueue_rob_i 5 (all in): store from AGU, word address, byte-aligned data, byte mask, IO flag, ROB tag.
REQ-006 SHALL have port enqueue_full_o  out  1  no free entry; the AGU holds its enqueue request while high.
REQ-007 SHALL have ports conflict_address_i 30 and conflict_bm_i 4 (in), load word address and byte mask; conflict_o out 1, the load overlaps a buffered store.
REQ-008 SHALL have port commit_store_i  in  1  ROB retires the oldest uncommitted store this cycle.
REQ-009 SHALL have ports st_req_o 1, st_addr_o 30, st_data_o 32, st_bm_o 4, st_io_o 1 (out) and st_ack_i 1 (in): the memory write port.
REQ-010 SHALL have port empty_o  out  1  no valid entries (for fences).

Function
REQ-011 SHALL be a circular FIFO with head (drain), commit and tail (enqueue) pointers of log2(DEPTH)+1 bits; the extra MSB separates full from empty on wrap.
REQ-012 SHALL accept an entry at tail when enqueue_en_i=1 and enqueue_full_o=0, and the entry is visible to the conflict check the next cycle.
REQ-013 SHALL drive enqueue_full_o combinationally, high exactly when occupancy==DEPTH.
REQ-014 SHALL ignore enqueue_en_i while full; the held request is accepted in the first cycle after an entry frees.
REQ-015 SHALL advance the commit pointer by one on commit_store_i when an uncommitted entry exists, and ignore commit_store_i otherwise.
REQ-016 SHALL on flush_i set tail to the commit pointer after that cycle's commit, drop any enqueue in the same cycle, and keep committed entries.
REQ-017 SHALL drive conflict_o combinationally high when any valid entry (committed or not) matches conflict_address_i and has (bm & conflict_bm_i)!=0.
REQ-018 SHALL run a drain FSM with states IDLE and WRITE.
REQ-019 IDLE: SHALL go to WRITE when head!=commit, latching the head entry onto the st_* outputs.
REQ-020 WRITE: SHALL hold st_req_o=1 with stable st_* outputs until st_ack_i=1; on ack SHALL pop head and, if another committed entry exists, present it the next cycle and stay in WRITE, else return to IDLE.
REQ-021 SHALL leave the drain unaffected by flush_i; an entry in WRITE is always committed.
REQ-022 SHALL free the popped entry for enqueue in the cycle after the ack.
REQ-023 SHALL drive empty_o high when head==tail and the FSM is IDLE.
REQ-024 SHALL allow enqueue, commit and drain-pop in the same cycle, with occupancy updated by +1 and -1 independently.

Reset
REQ-025 On cpu_reset_i SHALL clear all pointers and valid bits and set the FSM to IDLE; after reset st_req_o=0, enqueue_full_o=0, conflict_o=0 and empty_o=1.
REQ-026 Reset SHALL override flush_i, commit and ack in the same cycle, including a reset during a WRITE, which abandons that write.
REQ-027 Entry payload registers SHALL need no reset.

Structure
REQ-028 The shared package SHALL hold the entry struct (addr, data, bm, io, rob) and the drain state enum.
REQ-029 The overlap comparator SHALL be one sub-module, sb_overlap_cmp, instantiated per entry.

Verification
REQ-030 Test 1: enqueue addr 0x100, bm 0001, commit; hold ack low 3 cycles -> st_req_o high 3 cycles with stable outputs; on ack, empty_o=1 the next cycle.
REQ-031 Test 2: enqueue 8 entries without commit -> enqueue_full_o=1; hold a 9th request; commit 1 and ack the drain -> 9th entry accepted the cycle after the ack.
REQ-032 Test 3: enqueue 3 entries, commit 1, flush -> 1 entry drains, the other 2 never reach st_req_o, and tail equals the commit pointer.
REQ-033 Test 4: entry addr 0x40, bm 1100; load 0x40/bm 0011 -> conflict_o=0; load 0x40/bm 0100 -> conflict_o=1; load 0x41/bm 1111 -> conflict_o=0.
REQ-034 Test 5: commit 3 entries, ack every cycle -> 3 back-to-back writes with no IDLE cycle between them, then IDLE.
REQ-035 Test 6: assert reset mid-WRITE with enqueue, commit and flush also active -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: entry payload and drain FSM encoding.
package store_buffer_pkg;
    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int BM_W   = 4;
    localparam int ROB_W  = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BM_W-1:0]   bm;
        logic              io;
        logic [ROB_W-1:0]  rob;
    } sb_entry_t;

    typedef enum logic {
        DRAIN_IDLE  = 1'b0,
        DRAIN_WRITE = 1'b1
    } drain_state_t;
endpackage

// File: rtl/store_buffer_overlap_cmp.sv
// Per-entry load/store overlap check: same word and at least one common byte.
module sb_overlap_cmp
    import store_buffer_pkg::*;
(
    input  logic              valid,
    input  logic [ADDR_W-1:0] entry_addr,
    input  logic [BM_W-1:0]   entry_bm,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [BM_W-1:0]   load_bm,
    output logic              hit
);
    assign hit = valid && (entry_addr == load_addr) && (|(entry_bm & load_bm));
endmodule

// File: rtl/store_buffer.sv
// Circular store buffer: speculative stores enqueue at tail, retire via the
// commit pointer, and drain from head to memory through a two-state FSM.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              cpu_clock_i,
    input  logic              cpu_reset_i,
    input  logic              flush_i,
    input  logic              enqueue_en_i,
    input  logic [ADDR_W-1:0] enqueue_address_i,
    input  logic [DATA_W-1:0] enqueue_data_i,
    input  logic [BM_W-1:0]   enqueue_bm_i,
    input  logic              enqueue_io_i,
    input  logic [ROB_W-1:0]  enqueue_rob_i,
    output logic              enqueue_full_o,
    input  logic [ADDR_W-1:0] conflict_address_i,
    input  logic [BM_W-1:0]   conflict_bm_i,
    output logic              conflict_o,
    input  logic              commit_store_i,
    output logic              st_req_o,
    output logic [ADDR_W-1:0] st_addr_o,
    output logic [DATA_W-1:0] st_data_o,
    output logic [BM_W-1:0]   st_bm_o,
    output logic              st_io_o,
    input  logic              st_ack_i,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] head_q, commit_q, tail_q;
    logic [PW-1:0] occupancy, commit_nxt, head_plus;
    logic          accept, commit_ok, pop, more_committed;
    logic          load_st;
    logic [AW-1:0] load_idx;
    logic [DEPTH-1:0] hits;

    sb_entry_t    entries [DEPTH];
    sb_entry_t    st_q;
    drain_state_t state_q, state_nxt;

    assign occupancy      = tail_q - head_q;
    assign enqueue_full_o = (occupancy == PW'(DEPTH));
    assign accept         = enqueue_en_i && !enqueue_full_o && !flush_i;
    assign commit_ok      = commit_store_i && (commit_q != tail_q);
    assign commit_nxt     = commit_q + PW'(commit_ok);
    assign pop            = (state_q == DRAIN_WRITE) && st_ack_i;
    assign head_plus      = head_q + PW'(1);
    assign more_committed = (head_plus != commit_q);

    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            head_q   <= '0;
            commit_q <= '0;
            tail_q   <= '0;
            state_q  <= DRAIN_IDLE;
        end else begin
            state_q  <= state_nxt;
            commit_q <= commit_nxt;
            if (pop) head_q <= head_plus;
            // Flush rewinds tail onto this cycle's commit pointer, dropping any enqueue.
            if (flush_i)     tail_q <= commit_nxt;
            else if (accept) tail_q <= tail_q + PW'(1);
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        if (accept) begin
            entries[tail_q[AW-1:0]] <= '{addr: enqueue_address_i, data: enqueue_data_i,
                                         bm: enqueue_bm_i, io: enqueue_io_i,
                                         rob: enqueue_rob_i};
        end
        if (load_st) st_q <= entries[load_idx];
    end

    always_comb begin
        state_nxt = state_q;
        load_st   = 1'b0;
        load_idx  = head_q[AW-1:0];
        case (state_q)
            DRAIN_IDLE: begin
                if (head_q != commit_q) begin
                    state_nxt = DRAIN_WRITE;
                    load_st   = 1'b1;
                end
            end
            DRAIN_WRITE: begin
                if (st_ack_i) begin
                    if (more_committed) begin
                        load_st  = 1'b1;
                        load_idx = head_plus[AW-1:0];
                    end else begin
                        state_nxt = DRAIN_IDLE;
                    end
                end
            end
            default: state_nxt = DRAIN_IDLE;
        endcase
    end

    always_comb begin
        st_req_o  = (state_q == DRAIN_WRITE);
        st_addr_o = st_q.addr;
        st_data_o = st_q.data;
        st_bm_o   = st_q.bm;
        st_io_o   = st_q.io;
        empty_o   = (head_q == tail_q) && (state_q == DRAIN_IDLE);
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        logic [AW-1:0] offset;
        logic          valid;
        assign offset = AW'(i) - head_q[AW-1:0];
        assign valid  = ({1'b0, offset} < occupancy);
        sb_overlap_cmp u_cmp (
            .valid      (valid),
            .entry_addr (entries[i].addr),
            .entry_bm   (entries[i].bm),
            .load_addr  (conflict_address_i),
            .load_bm    (conflict_bm_i),
            .hit        (hits[i])
        );
    end

    assign conflict_o = |hits;
endmodule

// File: tb/tb_store_buffer.sv
// Store buffer bench: directed scenarios plus random traffic against a queue model.
module tb_store_buffer;
    localparam int DEPTH = 8;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  bm;
        logic        io;
    } m_entry_t;

    logic        clk = 1'b0;
    logic        rst, flush, en, io, commit, ack;
    logic [29:0] addr, caddr;
    logic [31:0] data;
    logic [3:0]  bm, cbm;
    logic [4:0]  rob;
    logic        full, conflict, st_req, st_io, empty;
    logic [29:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_bm;

    int n_checks = 0;
    int n_fail   = 0;

    m_entry_t mq[$];
    int       m_ncommit = 0;
    bit       m_writing = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .cpu_clock_i        (clk),
        .cpu_reset_i        (rst),
        .flush_i            (flush),
        .enqueue_en_i       (en),
        .enqueue_address_i  (addr),
        .enqueue_data_i     (data),
        .enqueue_bm_i       (bm),
        .enqueue_io_i       (io),
        .enqueue_rob_i      (rob),
        .enqueue_full_o     (full),
        .conflict_address_i (caddr),
        .conflict_bm_i      (cbm),
        .conflict_o         (conflict),
        .commit_store_i     (commit),
        .st_req_o           (st_req),
        .st_addr_o          (st_addr),
        .st_data_o          (st_data),
        .st_bm_o            (st_bm),
        .st_io_o            (st_io),
        .st_ack_i           (ack),
        .empty_o            (empty)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit e, input bit c, input bit f, input bit a, input bit r);
        en     = e;
        commit = c;
        flush  = f;
        ack    = a;
        rst    = r;
        addr   = 30'h40 + 30'($urandom_range(0, 7));
        data   = $urandom;
        bm     = 4'($urandom_range(0, 15));
        io     = 1'($urandom_range(0, 1));
        rob    = 5'($urandom_range(0, 31));
        caddr  = 30'h40 + 30'($urandom_range(0, 7));
        cbm    = 4'($urandom_range(0, 15));
    endtask

    // Inputs are already applied; compare outputs, advance the model, cross one edge.
    task automatic step();
        bit full_m, empty_m, conf_m, acc, com, nw;
        #1;
        full_m  = (mq.size() == DEPTH);
        empty_m = (mq.size() == 0) && !m_writing;
        conf_m  = 1'b0;
        foreach (mq[k])
            if (mq[k].addr == caddr && (mq[k].bm & cbm) != 4'd0) conf_m = 1'b1;
        check("full", 64'(full), 64'(full_m));
        check("empty", 64'(empty), 64'(empty_m));
        check("conflict", 64'(conflict), 64'(conf_m));
        check("st_req", 64'(st_req), 64'(m_writing));
        if (m_writing) begin
            check("st_addr", 64'(st_addr), 64'(mq[0].addr));
            check("st_data", 64'(st_data), 64'(mq[0].data));
            check("st_bm", 64'(st_bm), 64'(mq[0].bm));
            check("st_io", 64'(st_io), 64'(mq[0].io));
        end
        if (rst) begin
            mq.delete();
            m_ncommit = 0;
            m_writing = 0;
        end else begin
            acc = en && !full_m && !flush;
            com = commit && (m_ncommit < mq.size());
            if (m_writing) nw = ack ? (m_ncommit > 1) : 1'b1;
            else           nw = (m_ncommit > 0);
            if (m_writing && ack) begin
                void'(mq.pop_front());
                m_ncommit--;
            end
            if (com) m_ncommit++;
            if (flush) while (mq.size() > m_ncommit) void'(mq.pop_back());
            if (acc) mq.push_back('{addr: addr, data: data, bm: bm, io: io});
            m_writing = nw;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 1);
        step();
        step();
        drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        step();

        // Single store, write held off for three cycles.
        drive(1, 0, 0, 0, 0); addr = 30'h100; bm = 4'b0001; step();
        drive(0, 1, 0, 0, 0); step();
        repeat (3) begin drive(0, 0, 0, 0, 0); step(); end
        drive(0, 0, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0); step();
        check("t1_empty_after_ack", 64'(empty), 64'd1);

        // Fill to full, hold a ninth request, free one entry.
        do_reset();
        repeat (DEPTH) begin drive(1, 0, 0, 0, 0); step(); end
        repeat (2) begin drive(1, 0, 0, 0, 0); step(); end
        drive(1, 1, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0); step();
        drive(1, 0, 0, 1, 0); step();
        drive(1, 0, 0, 0, 0); step();
        drive(0, 0, 1, 0, 0); step();
        repeat (3) begin drive(0, 0, 0, 1, 0); step(); end

        // Three stores, one committed, then flush.
        do_reset();
        repeat (3) begin drive(1, 0, 0, 0, 0); step(); end
        drive(0, 1, 0, 0, 0); step();
        drive(0, 0, 1, 0, 0); step();
        repeat (6) begin drive(0, 0, 0, 1, 0); step(); end
        check("t3_empty", 64'(empty), 64'd1);

        // Byte-lane overlap cases.
        do_reset();
        drive(1, 0, 0, 0, 0); addr = 30'h40; bm = 4'b1100; step();
        drive(0, 0, 0, 0, 0); caddr = 30'h40; cbm = 4'b0011; step();
        check("t4_disjoint_lanes", 64'(conflict), 64'd0);
        drive(0, 0, 0, 0, 0); caddr = 30'h40; cbm = 4'b0100; step();
        check("t4_shared_lane", 64'(conflict), 64'd1);
        drive(0, 0, 0, 0, 0); caddr = 30'h41; cbm = 4'b1111; step();
        check("t4_other_word", 64'(conflict), 64'd0);

        // Back-to-back drains.
        do_reset();
        repeat (3) begin drive(1, 0, 0, 0, 0); step(); end
        repeat (3) begin drive(0, 1, 0, 0, 0); step(); end
        repeat (5) begin drive(0, 0, 0, 1, 0); step(); end

        // Reset in the middle of a write with everything else active.
        repeat (2) begin drive(1, 0, 0, 0, 0); step(); end
        drive(0, 1, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0); step();
        check("t6_in_write", 64'(st_req), 64'd1);
        drive(1, 1, 1, 1, 1); step();
        drive(0, 0, 0, 0, 0); step();
        check("t6_req_cleared", 64'(st_req), 64'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 299) == 0);
            if ($urandom_range(0, 1) == 1 && mq.size() > 0)
                caddr = mq[$urandom_range(0, mq.size() - 1)].addr;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
